// File: rtl/lp_cntr_updn_df.sv
// -----------------------------------------------------------------------------
// lp_cntr_updn_df
//
// Low-power loadable up/down counter with a dynamic terminal-value flag.
//
// Per rising clk edge the priority is: load (ld_n=0) > count (enable=1) > hold.
// In hold the count register is left untouched, so it does not toggle.
// SAT_MODE selects modular wrap (0) or saturation at 0 / all-ones (1).
// REG_TRMCNT selects a combinational (0) or registered (1) terminal flag.
// The terminal flag never alters the counting sequence.
//
// Parameters
//   WIDTH       counter / load / terminal-value width (2..64)
//   REG_TRMCNT  0: term_count_n combinational, 1: term_count_n registered
//   SAT_MODE    0: wrap modulo 2^WIDTH, 1: saturate at the bounds
//
// Ports
//   clk           in   1      single clock, rising-edge active
//   rst_n         in   1      asynchronous active-low reset (count -> 0)
//   enable        in   1      count enable, active-high
//   up_dn         in   1      1 = increment, 0 = decrement
//   ld_n          in   1      synchronous load, active-low
//   ld_count      in   WIDTH  load value
//   term_val      in   WIDTH  terminal value, may change every cycle
//   count         out  WIDTH  current count (register output)
//   term_count_n  out  1      0 when count equals term_val
// -----------------------------------------------------------------------------
module lp_cntr_updn_df #(
    parameter int WIDTH      = 8,
    parameter int REG_TRMCNT = 0,
    parameter int SAT_MODE   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             ld_n,
    input  logic [WIDTH-1:0] ld_count,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic             term_count_n
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MAX_C  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic             SAT_C  = (SAT_MODE != 32'sd0);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] next_count_s;
    logic             upd_s;

    // One counting step in the selected direction; in saturate mode a step
    // that would cross a bound leaves the value where it is.
    function automatic logic [WIDTH-1:0] step_count(
        input logic [WIDTH-1:0] cur,
        input logic             up
    );
        logic [WIDTH-1:0] res;
        if (up) begin
            if (SAT_C && (cur == MAX_C)) begin
                res = cur;
            end else begin
                res = cur + ONE_C;
            end
        end else begin
            if (SAT_C && (cur == ZERO_C)) begin
                res = cur;
            end else begin
                res = cur - ONE_C;
            end
        end
        return res;
    endfunction

    // Register write qualifier: only load or count cycles touch the register.
    assign upd_s = (~ld_n) | enable;

    // Next-count selection with load > count > hold priority.
    always_comb begin
        next_count_s = count_r;
        if (!ld_n) begin
            next_count_s = ld_count;
        end else if (enable) begin
            next_count_s = step_count(count_r, up_dn);
        end else begin
            next_count_s = count_r;
        end
    end

    // Count register; hold cycles are skipped entirely to avoid toggling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= ZERO_C;
        end else if (upd_s) begin
            count_r <= next_count_s;
        end
    end

    assign count = count_r;

    generate
        if (REG_TRMCNT != 32'sd0) begin : g_reg_tc
            logic tc_r;

            // Registered flag looks at the value count takes at this edge so
            // it lines up with count in the following cycle; it updates every
            // edge because term_val may change even while count holds.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tc_r <= 1'b1;
                end else begin
                    tc_r <= ~(next_count_s == term_val);
                end
            end

            assign term_count_n = tc_r;
        end else begin : g_comb_tc
            // Zero-latency compare; also live during reset (count is 0 then).
            assign term_count_n = ~(count_r == term_val);
        end
    endgenerate

endmodule

// File: tb/tb_lp_cntr_updn_df.sv
// -----------------------------------------------------------------------------
// tb_lp_cntr_updn_df
//
// Four instances share the same stimulus:
//   inst0: REG_TRMCNT=0 SAT_MODE=0    inst1: REG_TRMCNT=1 SAT_MODE=0
//   inst2: REG_TRMCNT=0 SAT_MODE=1    inst3: REG_TRMCNT=1 SAT_MODE=1
// The reference model keeps each counter as a plain integer and derives the
// expected flag from the counting rules; outputs are sampled 1 ns after edges.
// -----------------------------------------------------------------------------
module tb_lp_cntr_updn_df;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic            up_dn;
    logic            ld_n;
    logic [7:0]      ld_count;
    logic [7:0]      term_val;
    logic [3:0][7:0] cnt;
    logic [3:0]      tcn;

    int n_cmp;
    int n_fail;

    // reference model state
    int   mcnt  [4];
    logic mflag [4];

    lp_cntr_updn_df #(.WIDTH(8), .REG_TRMCNT(0), .SAT_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .ld_n(ld_n),
        .ld_count(ld_count), .term_val(term_val), .count(cnt[0]), .term_count_n(tcn[0]));
    lp_cntr_updn_df #(.WIDTH(8), .REG_TRMCNT(1), .SAT_MODE(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .ld_n(ld_n),
        .ld_count(ld_count), .term_val(term_val), .count(cnt[1]), .term_count_n(tcn[1]));
    lp_cntr_updn_df #(.WIDTH(8), .REG_TRMCNT(0), .SAT_MODE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .ld_n(ld_n),
        .ld_count(ld_count), .term_val(term_val), .count(cnt[2]), .term_count_n(tcn[2]));
    lp_cntr_updn_df #(.WIDTH(8), .REG_TRMCNT(1), .SAT_MODE(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn), .ld_n(ld_n),
        .ld_count(ld_count), .term_val(term_val), .count(cnt[3]), .term_count_n(tcn[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            mcnt[k]  = 0;
            mflag[k] = 1'b1;
        end
    endfunction

    // One clock edge of the counting rules, applied to every instance.
    function automatic void model_edge();
        for (int k = 0; k < 4; k++) begin
            int n;
            if (!ld_n)       n = int'(ld_count);
            else if (enable) n = up_dn ? mcnt[k] + 1 : mcnt[k] - 1;
            else             n = mcnt[k];
            if (k >= 2) begin
                if (n > 255) n = 255;
                if (n < 0)   n = 0;
            end else begin
                n = (n + 256) % 256;
            end
            mcnt[k] = n;
            if (k % 2 == 1) mflag[k] = (n != int'(term_val));
        end
    endfunction

    function automatic logic exp_tcn(int k);
        if (k % 2 == 1) return mflag[k];
        return (mcnt[k] != int'(term_val)) ? 1'b1 : 1'b0;
    endfunction

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; up_dn = 1'b1; ld_n = 1'b1;
        ld_count = 8'h5A; term_val = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (cnt[k] !== 8'h00) begin
                n_fail++; $display("FAIL reset_cnt inst%0d: got %h want 00", k, cnt[k]);
            end
            n_cmp++;
            // comb flag follows count==term_val (both 0), registered flag is 1
            if (tcn[k] !== ((k % 2 == 1) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL reset_tcn inst%0d: got %b want %b", k, tcn[k], (k % 2 == 1));
            end
        end
        #2 rst_n = 1'b1;
        enable = 1'b0;
        advance();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (cnt[k] !== 8'(mcnt[k]) || tcn[k] !== exp_tcn(k)) begin
                n_fail++; $display("FAIL post_reset inst%0d: got %h/%b want %h/%b", k, cnt[k], tcn[k], 8'(mcnt[k]), exp_tcn(k));
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [4];
        seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        term_val = 8'hAA;
        ld_n = 1'b0; ld_count = 8'hFE; enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            advance();
            ld_n = 1'b1; enable = 1'b1; up_dn = 1'b1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (cnt[k] !== seq[c]) begin
                    n_fail++; $display("FAIL wrap_seq inst%0d cyc%0d: got %h want %h", k, c, cnt[k], seq[c]);
                end
            end
            for (int k = 2; k < 4; k++) begin
                n_cmp++;
                if (cnt[k] !== 8'(mcnt[k])) begin
                    n_fail++; $display("FAIL sat_up inst%0d cyc%0d: got %h want %h", k, c, cnt[k], 8'(mcnt[k]));
                end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_sat();
        logic [7:0] seq [4];
        seq = '{8'h01, 8'h00, 8'h00, 8'h00};
        term_val = 8'h00;
        ld_n = 1'b0; ld_count = 8'h01; enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            advance();
            ld_n = 1'b1; enable = 1'b1; up_dn = 1'b0;
            for (int k = 2; k < 4; k++) begin
                n_cmp++;
                if (cnt[k] !== seq[c]) begin
                    n_fail++; $display("FAIL sat_seq inst%0d cyc%0d: got %h want %h", k, c, cnt[k], seq[c]);
                end
                n_cmp++;
                // held at 0 == term_val keeps the flag asserted every cycle
                if (tcn[k] !== (c == 0)) begin
                    n_fail++; $display("FAIL sat_tcn inst%0d cyc%0d: got %b want %b", k, c, tcn[k], (c == 0));
                end
            end
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (cnt[k] !== 8'(mcnt[k])) begin
                    n_fail++; $display("FAIL wrap_dn inst%0d cyc%0d: got %h want %h", k, c, cnt[k], 8'(mcnt[k]));
                end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_comb_flag();
        term_val = 8'h11; ld_n = 1'b0; ld_count = 8'h10; enable = 1'b0;
        advance();
        ld_n = 1'b1;
        advance();
        n_cmp++;
        if (tcn[0] !== 1'b1) begin
            n_fail++; $display("FAIL comb_before: got %b want 1", tcn[0]);
        end
        #2 term_val = 8'h10;
        #1;
        n_cmp++;
        if (tcn[0] !== 1'b0) begin
            n_fail++; $display("FAIL comb_same_cycle: got %b want 0", tcn[0]);
        end
        n_cmp++;
        if (tcn[1] !== 1'b1) begin
            n_fail++; $display("FAIL reg_between_edges: got %b want 1", tcn[1]);
        end
        advance();
        n_cmp++;
        if (tcn[1] !== 1'b0 || cnt[1] !== 8'h10) begin
            n_fail++; $display("FAIL reg_next_edge: got %b/%h want 0/10", tcn[1], cnt[1]);
        end
    endtask

    task automatic test_reg_flag();
        logic [7:0] seq [4];
        seq = '{8'h03, 8'h04, 8'h05, 8'h06};
        term_val = 8'h05; ld_n = 1'b0; ld_count = 8'h03; enable = 1'b0;
        for (int c = 0; c < 4; c++) begin
            advance();
            ld_n = 1'b1; enable = 1'b1; up_dn = 1'b1;
            n_cmp++;
            if (cnt[1] !== seq[c] || tcn[1] !== (seq[c] != 8'h05)) begin
                n_fail++; $display("FAIL reg_align cyc%0d: got %h/%b want %h/%b", c, cnt[1], tcn[1], seq[c], (seq[c] != 8'h05));
            end
            n_cmp++;
            if (tcn[0] !== exp_tcn(0)) begin
                n_fail++; $display("FAIL comb_align cyc%0d: got %b want %b", c, tcn[0], exp_tcn(0));
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_load_priority();
        ld_n = 1'b0; ld_count = 8'h7F; enable = 1'b0;
        advance();
        ld_count = 8'h40; enable = 1'b1; up_dn = 1'b1;
        advance();
        ld_n = 1'b1; enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (cnt[k] !== 8'h40) begin
                n_fail++; $display("FAIL load_wins inst%0d: got %h want 40", k, cnt[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        term_val = 8'h22; ld_n = 1'b0; ld_count = 8'h33; enable = 1'b0;
        advance();
        ld_n = 1'b1; enable = 1'b1; up_dn = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (cnt[k] !== 8'h00 || tcn[k] !== exp_tcn(k)) begin
                n_fail++; $display("FAIL async_rst inst%0d: got %h/%b want 00/%b", k, cnt[k], tcn[k], exp_tcn(k));
            end
        end
        #2 rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            advance();
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (cnt[k] !== 8'(c + 1)) begin
                    n_fail++; $display("FAIL resume inst%0d cyc%0d: got %h want %h", k, c, cnt[k], 8'(c + 1));
                end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ld_n   = ($urandom_range(0, 9) != 0);
            enable = ($urandom_range(0, 3) != 0);
            up_dn  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0:       ld_count = 8'hFF;
                1:       ld_count = 8'h00;
                default: ld_count = 8'($urandom);
            endcase
            term_val = ($urandom_range(0, 1) == 1) ? 8'(mcnt[$urandom_range(0, 3)] + $urandom_range(0, 2) - 1) : 8'($urandom);
            advance();
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (cnt[k] !== 8'(mcnt[k]) || tcn[k] !== exp_tcn(k)) begin
                    n_fail++; $display("FAIL rand inst%0d cyc%0d: got %h/%b want %h/%b", k, c, cnt[k], tcn[k], 8'(mcnt[k]), exp_tcn(k));
                end
            end
            // mid-cycle term_val change: comb flags react, registered do not
            term_val = 8'(mcnt[$urandom_range(0, 3)]);
            #1;
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (tcn[k] !== exp_tcn(k)) begin
                    n_fail++; $display("FAIL rand_mid inst%0d cyc%0d: got %b want %b", k, c, tcn[k], exp_tcn(k));
                end
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_wrap();
        test_sat();
        test_comb_flag();
        test_reg_flag();
        test_load_priority();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
